// File: rtl/team_06_esp_tx_feeder.sv
// Sample FIFO and SPI bit-clock generator feeding one stable byte per frame to the ESP serializer.
// Optional macro ESP_FEEDER_SYNC_BYTE_EN prefixes every sample with a 0xA5 sync byte.
module team_06_esp_tx_feeder #(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     spiclk,
    output logic                     past_spiclk,
    output logic [7:0]               tx_byte,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     underrun,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SYNC, MSB, LSB} state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bcnt;
    logic             fall;
    logic             adv;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             empty;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      hold;
    logic [7:0]       tx_nxt;
    logic             underrun_nxt;

    // Bit clock: a high phase always completes before the clock parks low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            spiclk      <= 1'b0;
            past_spiclk <= 1'b0;
        end else begin
            past_spiclk <= spiclk;
            if (en || spiclk) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    spiclk  <= ~spiclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
            end
        end
    end

    assign fall = past_spiclk & ~spiclk;
    assign adv  = fall && (bcnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcnt <= '0;
        else if (fall) bcnt <= bcnt + 1'b1;
    end

    // FIFO: readiness and emptiness come from the registered fill only.
    assign sample_ready = (fill < FULL_LVL);
    assign push         = sample_valid & sample_ready;
    assign empty        = (fill == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (sample_valid && !sample_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) hold <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_byte  <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_byte  <= tx_nxt;
            underrun <= underrun_nxt;
        end
    end

    // Sequencer only moves on a byte boundary; tx_byte is held between boundaries.
    always_comb begin
        state_nxt    = state;
        tx_nxt       = tx_byte;
        underrun_nxt = 1'b0;
        pop          = 1'b0;
        if (adv) begin
            case (state)
                IDLE, LSB: begin
                    if (!empty) begin
                        pop = 1'b1;
`ifdef ESP_FEEDER_SYNC_BYTE_EN
                        state_nxt = SYNC;
                        tx_nxt    = 8'hA5;
`else
                        state_nxt = MSB;
                        tx_nxt    = mem[rd_ptr][15:8];
`endif
                    end else begin
                        state_nxt    = IDLE;
                        tx_nxt       = 8'h00;
                        underrun_nxt = 1'b1;
                    end
                end
                SYNC: begin
                    state_nxt = MSB;
                    tx_nxt    = hold[15:8];
                end
                MSB: begin
                    state_nxt = LSB;
                    tx_nxt    = hold[7:0];
                end
                default: begin
                    state_nxt = IDLE;
                    tx_nxt    = 8'h00;
                end
            endcase
        end
    end

endmodule
